// File: rtl/scale_mux_pkg.sv
// ============================================================================
//  Module      : scale_mux_pkg
//  Description : Shared constants, state types and helpers for the
//                round-robin arbitrated scale mux (scale_arb_mux).
//  Contents    : C_DEF_WIDTH / C_DEF_NCH  default data width / channel count
//                out_state_t              output stage states {EMPTY, FULL}
//                lock_state_t             burst lock states   {IDLE, LOCKED}
//                sel_width(n)             $clog2(n), never less than 1
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package scale_mux_pkg;

    localparam int C_DEF_WIDTH = 8;
    localparam int C_DEF_NCH   = 4;

    typedef enum logic [0:0] {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } out_state_t;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } lock_state_t;

    // Index width for n channels; a single channel still needs one bit
    function automatic int sel_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

`default_nettype wire

// File: rtl/scale_arb_mux_arbiter.sv
// ============================================================================
//  Module      : rr_arbiter
//  Description : Round-robin arbiter. The search starts at the pointer and
//                wraps modulo NCH; the first requesting channel wins. The
//                pointer moves past the winner only when en is high and at
//                least one request is present.
//  Ports       : clk, rst      clock, asynchronous active-high reset
//                req[NCH]      request vector
//                en            allow the pointer to advance this cycle
//                gnt[NCH]      one-hot grant (zero when no request)
//                gnt_idx       index of the granted channel
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arbiter
    import scale_mux_pkg::*;
#(
    parameter  int NCH  = C_DEF_NCH,
    localparam int SELW = sel_width(NCH)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NCH-1:0]  req,
    input  logic            en,
    output logic [NCH-1:0]  gnt,
    output logic [SELW-1:0] gnt_idx
);

    localparam logic [SELW-1:0] C_LAST = SELW'(NCH - 1);

    logic [SELW-1:0] r_ptr;
    logic [SELW-1:0] w_cand;
    logic            w_found;

    // Walk NCH candidates starting at the pointer; the candidate index
    // wraps explicitly so non-power-of-two channel counts work.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        w_found = 1'b0;
        w_cand  = r_ptr;
        for (int k = 0; k < NCH; k++) begin
            if (!w_found && req[w_cand]) begin
                w_found     = 1'b1;
                gnt[w_cand] = 1'b1;
                gnt_idx     = w_cand;
            end
            w_cand = (w_cand == C_LAST) ? '0 : w_cand + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr <= '0;
        end else if (en && (|req)) begin
            r_ptr <= (gnt_idx == C_LAST) ? '0 : gnt_idx + 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/scale_arb_mux.sv
// ============================================================================
//  Module      : scale_arb_mux
//  Description : NCH:1 data mux with per-channel valid/ready handshakes, a
//                round-robin arbiter and a single-entry registered output
//                stage. Sustains one word per clock; stalls hold the output.
//  Ports       : clk, rst          clock, asynchronous active-high reset
//                in_data[NCH*W]    channel i at bits [i*WIDTH +: WIDTH]
//                in_valid[NCH]     channel has a word
//                in_ready[NCH]     one-hot/zero accept strobe (combinational)
//                out_data[W]       registered winning word
//                out_valid         out_data holds an unconsumed word
//                out_ready         consumer takes out_data this cycle
//                out_sel[SELW]     channel that supplied out_data
//  Options     : SCALE_ARB_MUX_LOCK_EN adds in_last[NCH] / out_last. A beat
//                without in_last locks the arbiter on its channel until that
//                channel's in_last beat is accepted.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module scale_arb_mux
    import scale_mux_pkg::*;
#(
    parameter  int WIDTH = C_DEF_WIDTH,
    parameter  int NCH   = C_DEF_NCH,
    localparam int SELW  = sel_width(NCH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NCH*WIDTH-1:0] in_data,
    input  logic [NCH-1:0]       in_valid,
    output logic [NCH-1:0]       in_ready,
    output logic [WIDTH-1:0]     out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [SELW-1:0]      out_sel
`ifdef SCALE_ARB_MUX_LOCK_EN
    ,
    input  logic [NCH-1:0]       in_last,
    output logic                 out_last
`endif
);

    out_state_t       r_ostate;
    logic [WIDTH-1:0] r_out_data;
    logic [SELW-1:0]  r_out_sel;

    logic             w_load;
    logic             w_accept_ok;
    logic             w_grant;
    logic [NCH-1:0]   w_req;
    logic [NCH-1:0]   w_gnt;
    logic [SELW-1:0]  w_gnt_idx;
    logic             w_ptr_en;
    logic [WIDTH-1:0] w_win_data;

    // The stage can take a word when empty or when its word leaves now.
    // Reset also blocks acceptance so nothing is handshaken while held.
    assign w_load      = (r_ostate == EMPTY) || out_ready;
    assign w_accept_ok = w_load && !rst;

`ifdef SCALE_ARB_MUX_LOCK_EN
    lock_state_t      r_lock;
    logic [SELW-1:0]  r_lock_ch;
    logic             r_out_last;
    logic             w_win_last;

    // While locked only the owning channel may request.
    always_comb begin
        w_req = in_valid;
        if (r_lock == LOCKED) begin
            w_req            = '0;
            w_req[r_lock_ch] = in_valid[r_lock_ch];
        end
    end

    assign w_win_last = |(w_gnt & in_last);

    // Pointer moves only when a burst ends (single-beat bursts included).
    assign w_ptr_en = w_accept_ok && w_win_last;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lock    <= IDLE;
            r_lock_ch <= '0;
        end else if (w_grant) begin
            unique case (r_lock)
                IDLE: begin
                    if (!w_win_last) begin
                        r_lock    <= LOCKED;
                        r_lock_ch <= w_gnt_idx;
                    end
                end
                LOCKED: begin
                    if (w_win_last) begin
                        r_lock <= IDLE;
                    end
                end
                default: r_lock <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_last <= 1'b0;
        end else if (w_grant) begin
            r_out_last <= w_win_last;
        end
    end

    assign out_last = r_out_last;
`else
    assign w_req    = in_valid;
    assign w_ptr_en = w_accept_ok;
`endif

    rr_arbiter #(
        .NCH     (NCH)
    ) u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     (w_req),
        .en      (w_ptr_en),
        .gnt     (w_gnt),
        .gnt_idx (w_gnt_idx)
    );

    assign w_grant  = w_accept_ok && (|w_gnt);
    assign in_ready = w_gnt & {NCH{w_accept_ok}};

    // One-hot grant selects the winning word
    always_comb begin
        w_win_data = '0;
        for (int i = 0; i < NCH; i++) begin
            if (w_gnt[i]) begin
                w_win_data = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    // Output stage: a grant always loads; FULL drains to EMPTY only when
    // the consumer takes the word and nothing replaces it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ostate   <= EMPTY;
            r_out_data <= '0;
            r_out_sel  <= '0;
        end else begin
            unique case (r_ostate)
                EMPTY: begin
                    if (w_grant) begin
                        r_ostate   <= FULL;
                        r_out_data <= w_win_data;
                        r_out_sel  <= w_gnt_idx;
                    end
                end
                FULL: begin
                    if (w_grant) begin
                        r_out_data <= w_win_data;
                        r_out_sel  <= w_gnt_idx;
                    end else if (out_ready) begin
                        r_ostate <= EMPTY;
                    end
                end
                default: r_ostate <= EMPTY;
            endcase
        end
    end

    assign out_valid = (r_ostate == FULL);
    assign out_data  = r_out_data;
    assign out_sel   = r_out_sel;

endmodule

`default_nettype wire
